// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset control FSM with memory watchdog, illegal-opcode trap and instret.
// Optional macro JAL_JALR_EN adds JAL/JALR through the JUMP state; otherwise they trap as illegal.
module multicycle_control_unit #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             mdr_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             target_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op_main,
    output logic             reg_write_enable,
    output logic             mem_to_reg,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_JUMP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef JAL_JALR_EN
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q;
    logic             trap_q, trap_d;
    logic [1:0]       cause_q, cause_d;
    logic [TO_W-1:0]  wdog_q, wdog_d;
    logic             retire;
    logic             memWait;
    logic             timeoutHit;

    // A mem_ready arriving in the final watchdog cycle wins over the timeout.
    assign memWait    = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
    assign timeoutHit = (TIMEOUT != 0) && memWait && (wdog_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        trap_d  = trap_q;
        cause_d = cause_q;
        wdog_d  = '0;
        retire  = 1'b0;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else if (opcode == OP_STORE) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeoutHit) begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                    cause_d = 2'b10;
                end else if (TIMEOUT != 0) begin
                    wdog_d = wdog_q + TO_W'(1);
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: state_d = S_EXEC;
`ifdef JAL_JALR_EN
                    OP_JAL, OP_JALR: state_d = S_JUMP;
`endif
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC: begin
                case (opcode)
                    OP_R, OP_I:        state_d = S_WB;
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    OP_BRANCH: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    default: begin
                        state_d = S_TRAP;
                        trap_d  = 1'b1;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`ifdef JAL_JALR_EN
            S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
`endif
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
            wdog_q    <= '0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_d;
            cause_q <= cause_d;
            wdog_q  <= wdog_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // Controls are forced low during reset so FETCH does not request memory until release.
    always_comb begin
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        iord             = 1'b0;
        ir_write         = 1'b0;
        mdr_write        = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        target_write     = 1'b0;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        alu_op_main      = 2'b00;
        reg_write_enable = 1'b0;
        mem_to_reg       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b    = 2'b11;
                    target_write = 1'b1;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_R: begin
                            alu_src_a   = 1'b1;
                            alu_op_main = 2'b10;
                        end
                        OP_I: begin
                            alu_src_a   = 1'b1;
                            alu_src_b   = 2'b10;
                            alu_op_main = 2'b10;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 2'b10;
                        end
                        OP_BRANCH: begin
                            alu_src_a   = 1'b1;
                            alu_op_main = 2'b01;
                            pc_src      = 1'b1;
                            pc_write    = zero;
                        end
                        default: alu_src_a = 1'b0;
                    endcase
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_we    = (opcode == OP_STORE);
                    mdr_write = mem_ready && (opcode != OP_STORE);
                end
                S_WB: begin
                    reg_write_enable = 1'b1;
                    mem_to_reg       = (opcode == OP_LOAD);
                end
`ifdef JAL_JALR_EN
                S_JUMP: begin
                    reg_write_enable = 1'b1;
                    pc_write         = 1'b1;
                    if (opcode == OP_JALR) begin
                        alu_src_a = 1'b1;
                        alu_src_b = 2'b10;
                    end else begin
                        pc_src = 1'b1;
                    end
                end
`endif
                default: mem_req = 1'b0;
            endcase
        end
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit (CNT_W=4 so the counter wrap is reachable).
// Inputs change just after the falling edge; outputs are checked 1 time unit later.
module tb_multicycle_control_unit;

    localparam int TB_CNT_W = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    // {req,we,iord, ir,mdr,pcw,pcsrc, tw,asa, asb, aop, rwe,m2r}
    localparam logic [14:0] C_ZERO       = 15'b0_0_0_0_0_0_0_0_0_00_00_0_0;
    localparam logic [14:0] C_FETCH_WAIT = 15'b1_0_0_0_0_0_0_0_0_01_00_0_0;
    localparam logic [14:0] C_FETCH_DONE = 15'b1_0_0_1_0_1_0_0_0_01_00_0_0;
    localparam logic [14:0] C_DECODE     = 15'b0_0_0_0_0_0_0_1_0_11_00_0_0;
    localparam logic [14:0] C_EXEC_R     = 15'b0_0_0_0_0_0_0_0_1_00_10_0_0;
    localparam logic [14:0] C_EXEC_I     = 15'b0_0_0_0_0_0_0_0_1_10_10_0_0;
    localparam logic [14:0] C_EXEC_LS    = 15'b0_0_0_0_0_0_0_0_1_10_00_0_0;
    localparam logic [14:0] C_EXEC_BT    = 15'b0_0_0_0_0_1_1_0_1_00_01_0_0;
    localparam logic [14:0] C_EXEC_BN    = 15'b0_0_0_0_0_0_1_0_1_00_01_0_0;
    localparam logic [14:0] C_MEM_LWAIT  = 15'b1_0_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [14:0] C_MEM_LDONE  = 15'b1_0_1_0_1_0_0_0_0_00_00_0_0;
    localparam logic [14:0] C_MEM_STORE  = 15'b1_1_1_0_0_0_0_0_0_00_00_0_0;
    localparam logic [14:0] C_WB_ALU     = 15'b0_0_0_0_0_0_0_0_0_00_00_1_0;
    localparam logic [14:0] C_WB_LOAD    = 15'b0_0_0_0_0_0_0_0_0_00_00_1_1;
    localparam logic [14:0] C_JUMP_JAL   = 15'b0_0_0_0_0_1_1_0_0_00_00_1_0;
    localparam logic [14:0] C_JUMP_JALR  = 15'b0_0_0_0_0_1_0_0_1_10_00_1_0;

    logic                clk;
    logic                rst;
    logic [6:0]          opcode;
    logic                zero;
    logic                mem_ready;
    logic                mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src;
    logic                target_write, alu_src_a, reg_write_enable, mem_to_reg, trap;
    logic [1:0]          alu_src_b, alu_op_main, trap_cause;
    logic [TB_CNT_W-1:0] instret;
    logic [2:0]          state;
    logic [14:0]         ctrlVec;

    int                  checks;
    int                  errors;
    logic [TB_CNT_W-1:0] expInstret;

    multicycle_control_unit #(.CNT_W(TB_CNT_W), .TIMEOUT(16), .TO_W(8)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .mdr_write(mdr_write), .pc_write(pc_write), .pc_src(pc_src),
        .target_write(target_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op_main(alu_op_main), .reg_write_enable(reg_write_enable),
        .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
        .instret(instret), .state(state)
    );

    assign ctrlVec = {mem_req, mem_we, iord, ir_write, mdr_write, pc_write, pc_src,
                      target_write, alu_src_a, alu_src_b, alu_op_main,
                      reg_write_enable, mem_to_reg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset asserted: everything quiet, including mem_req; release lands in FETCH.
    task automatic test_reset();
        rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0; expInstret = '0;
        #2;
        checks++;
        if ({state, ctrlVec, trap, trap_cause, instret} !== 25'd0) begin
            errors++;
            $display("[TB] FAIL reset_state got %b required 0", {state, ctrlVec, trap, trap_cause, instret});
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd0, C_FETCH_WAIT}) begin
            errors++;
            $display("[TB] FAIL reset_release got %b required %b", {state, ctrlVec}, {3'd0, C_FETCH_WAIT});
        end
    endtask

    // R-type then I-type with 0-wait memory, 4 cycles each.
    task automatic test_alu_ops();
        logic [14:0] expExec;
        for (int k = 0; k < 2; k++) begin
            opcode  = (k == 0) ? OP_R : OP_I;
            expExec = (k == 0) ? C_EXEC_R : C_EXEC_I;
            mem_ready = 1'b1; #1;
            checks++;
            if ({state, ctrlVec} !== {3'd0, C_FETCH_DONE}) begin
                errors++;
                $display("[TB] FAIL alu_fetch got %b required %b", {state, ctrlVec}, {3'd0, C_FETCH_DONE});
            end
            @(negedge clk); mem_ready = 1'b0; #1;
            checks++;
            if ({state, ctrlVec} !== {3'd1, C_DECODE}) begin
                errors++;
                $display("[TB] FAIL alu_decode got %b required %b", {state, ctrlVec}, {3'd1, C_DECODE});
            end
            @(negedge clk); #1;
            checks++;
            if ({state, ctrlVec} !== {3'd2, expExec}) begin
                errors++;
                $display("[TB] FAIL alu_exec got %b required %b", {state, ctrlVec}, {3'd2, expExec});
            end
            @(negedge clk); #1;
            checks++;
            if ({state, ctrlVec, instret} !== {3'd4, C_WB_ALU, expInstret}) begin
                errors++;
                $display("[TB] FAIL alu_wb got %b required %b", {state, ctrlVec, instret}, {3'd4, C_WB_ALU, expInstret});
            end
            @(negedge clk); expInstret++; #1;
            checks++;
            if ({state, ctrlVec, instret} !== {3'd0, C_FETCH_WAIT, expInstret}) begin
                errors++;
                $display("[TB] FAIL alu_retire got %b required %b", {state, ctrlVec, instret}, {3'd0, C_FETCH_WAIT, expInstret});
            end
        end
    endtask

    // Load with 3 wait cycles in MEM: 8 cycles total, mdr_write only on the ready cycle.
    task automatic test_load_wait();
        opcode = OP_LW; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd1, C_DECODE}) begin
            errors++;
            $display("[TB] FAIL load_decode got %b required %b", {state, ctrlVec}, {3'd1, C_DECODE});
        end
        @(negedge clk); #1;
        checks++;
        if ({state, ctrlVec} !== {3'd2, C_EXEC_LS}) begin
            errors++;
            $display("[TB] FAIL load_exec got %b required %b", {state, ctrlVec}, {3'd2, C_EXEC_LS});
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({state, ctrlVec} !== {3'd3, C_MEM_LWAIT}) begin
                errors++;
                $display("[TB] FAIL load_mem_wait%0d got %b required %b", i, {state, ctrlVec}, {3'd3, C_MEM_LWAIT});
            end
            @(negedge clk);
        end
        mem_ready = 1'b1; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd3, C_MEM_LDONE}) begin
            errors++;
            $display("[TB] FAIL load_mem_done got %b required %b", {state, ctrlVec}, {3'd3, C_MEM_LDONE});
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd4, C_WB_LOAD}) begin
            errors++;
            $display("[TB] FAIL load_wb got %b required %b", {state, ctrlVec}, {3'd4, C_WB_LOAD});
        end
        @(negedge clk); expInstret++; #1;
        checks++;
        if ({state, instret} !== {3'd0, expInstret}) begin
            errors++;
            $display("[TB] FAIL load_retire got %b required %b", {state, instret}, {3'd0, expInstret});
        end
    endtask

    // Store retires straight from MEM: 4 cycles.
    task automatic test_store();
        opcode = OP_SW; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({state, ctrlVec} !== {3'd2, C_EXEC_LS}) begin
            errors++;
            $display("[TB] FAIL store_exec got %b required %b", {state, ctrlVec}, {3'd2, C_EXEC_LS});
        end
        @(negedge clk); mem_ready = 1'b1; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd3, C_MEM_STORE}) begin
            errors++;
            $display("[TB] FAIL store_mem got %b required %b", {state, ctrlVec}, {3'd3, C_MEM_STORE});
        end
        @(negedge clk); mem_ready = 1'b0; expInstret++; #1;
        checks++;
        if ({state, instret} !== {3'd0, expInstret}) begin
            errors++;
            $display("[TB] FAIL store_retire got %b required %b", {state, instret}, {3'd0, expInstret});
        end
    endtask

    // beq taken (zero=1) then not taken (zero=0); 3 cycles each.
    task automatic test_branch();
        logic [14:0] expExec;
        for (int k = 0; k < 2; k++) begin
            opcode  = OP_BEQ;
            zero    = (k == 0);
            expExec = (k == 0) ? C_EXEC_BT : C_EXEC_BN;
            mem_ready = 1'b1;
            @(negedge clk); mem_ready = 1'b0;
            @(negedge clk); #1;
            checks++;
            if ({state, ctrlVec} !== {3'd2, expExec}) begin
                errors++;
                $display("[TB] FAIL branch_exec%0d got %b required %b", k, {state, ctrlVec}, {3'd2, expExec});
            end
            @(negedge clk); expInstret++; #1;
            checks++;
            if ({state, instret} !== {3'd0, expInstret}) begin
                errors++;
                $display("[TB] FAIL branch_retire%0d got %b required %b", k, {state, instret}, {3'd0, expInstret});
            end
        end
        zero = 1'b0;
    endtask

    // mem_ready arrives on the 16th waiting cycle: completes normally, no trap.
    task automatic test_fetch_late();
        opcode = OP_I; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if ({state, ctrlVec} !== {3'd0, C_FETCH_WAIT}) begin
                errors++;
                $display("[TB] FAIL late_wait%0d got %b required %b", i, {state, ctrlVec}, {3'd0, C_FETCH_WAIT});
            end
            @(negedge clk);
        end
        mem_ready = 1'b1; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd0, C_FETCH_DONE}) begin
            errors++;
            $display("[TB] FAIL late_done got %b required %b", {state, ctrlVec}, {3'd0, C_FETCH_DONE});
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        checks++;
        if ({state, trap} !== {3'd1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL late_decode got %b required %b", {state, trap}, {3'd1, 1'b0});
        end
        @(negedge clk); @(negedge clk); @(negedge clk); expInstret++; #1;
        checks++;
        if ({state, instret} !== {3'd0, expInstret}) begin
            errors++;
            $display("[TB] FAIL late_retire got %b required %b", {state, instret}, {3'd0, expInstret});
        end
    endtask

    // Async reset mid-MEM store clears outputs before any clock edge.
    task automatic test_async_reset();
        opcode = OP_SW; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({state, ctrlVec, instret} !== {3'd3, C_MEM_STORE, expInstret}) begin
            errors++;
            $display("[TB] FAIL async_pre got %b required %b", {state, ctrlVec, instret}, {3'd3, C_MEM_STORE, expInstret});
        end
        #1 rst = 1'b1; expInstret = '0; #1;
        checks++;
        if ({state, ctrlVec, instret} !== {3'd0, C_ZERO, expInstret}) begin
            errors++;
            $display("[TB] FAIL async_clear got %b required %b", {state, ctrlVec, instret}, {3'd0, C_ZERO, expInstret});
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({state, ctrlVec} !== {3'd0, C_FETCH_WAIT}) begin
            errors++;
            $display("[TB] FAIL async_release got %b required %b", {state, ctrlVec}, {3'd0, C_FETCH_WAIT});
        end
    endtask

    // 17 retirements on a 4-bit counter: 16 wraps to 0, 17 gives 1.
    task automatic test_wrap();
        for (int i = 0; i < 17; i++) begin
            opcode = OP_BEQ; zero = 1'b0; mem_ready = 1'b1;
            @(negedge clk); mem_ready = 1'b0;
            @(negedge clk); @(negedge clk); expInstret++; #1;
            if (i == 15) begin
                checks++;
                if (instret !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL wrap_16 got %0d required 0", instret);
                end
            end
        end
        checks++;
        if ({state, instret} !== {3'd0, 4'd1}) begin
            errors++;
            $display("[TB] FAIL wrap_17 got %b required %b", {state, instret}, {3'd0, 4'd1});
        end
    endtask

    // Illegal opcode traps, stays silent for 20 cycles despite mem_ready, rst recovers.
    task automatic test_illegal();
        logic [TB_CNT_W-1:0] frozen;
        frozen = expInstret;
        opcode = OP_BAD; mem_ready = 1'b1;
        @(negedge clk); mem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0]; #1;
            checks++;
            if ({trap, trap_cause, state, ctrlVec, instret} !== {1'b1, 2'b01, 3'd5, C_ZERO, frozen}) begin
                errors++;
                $display("[TB] FAIL illegal_trap%0d got %b required %b", i, {trap, trap_cause, state, ctrlVec, instret}, {1'b1, 2'b01, 3'd5, C_ZERO, frozen});
            end
            @(negedge clk);
        end
        mem_ready = 1'b0; rst = 1'b1; expInstret = '0; #1;
        checks++;
        if ({trap, trap_cause, state, instret} !== {1'b0, 2'b00, 3'd0, expInstret}) begin
            errors++;
            $display("[TB] FAIL illegal_reset got %b required %b", {trap, trap_cause, state, instret}, {1'b0, 2'b00, 3'd0, expInstret});
        end
        @(negedge clk); rst = 1'b0; #1;
    endtask

    // No mem_ready for 16 FETCH cycles: bus-timeout trap.
    task automatic test_timeout();
        opcode = OP_R; mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            checks++;
            if ({state, trap} !== {3'd0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL timeout_wait%0d got %b required %b", i, {state, trap}, {3'd0, 1'b0});
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if ({trap, trap_cause, state, ctrlVec} !== {1'b1, 2'b10, 3'd5, C_ZERO}) begin
            errors++;
            $display("[TB] FAIL timeout_trap got %b required %b", {trap, trap_cause, state, ctrlVec}, {1'b1, 2'b10, 3'd5, C_ZERO});
        end
        rst = 1'b1; expInstret = '0;
        @(negedge clk); rst = 1'b0; #1;
    endtask

    // JAL/JALR: JUMP state when enabled, illegal-opcode trap otherwise.
    task automatic test_jump();
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? OP_JAL : OP_JALR; mem_ready = 1'b1;
            @(negedge clk); mem_ready = 1'b0;
            @(negedge clk); #1;
`ifdef JAL_JALR_EN
            checks++;
            if ({state, ctrlVec} !== {3'd6, (k == 0) ? C_JUMP_JAL : C_JUMP_JALR}) begin
                errors++;
                $display("[TB] FAIL jump%0d got %b required %b", k, {state, ctrlVec}, {3'd6, (k == 0) ? C_JUMP_JAL : C_JUMP_JALR});
            end
            @(negedge clk); expInstret++; #1;
            checks++;
            if ({state, instret} !== {3'd0, expInstret}) begin
                errors++;
                $display("[TB] FAIL jump_retire%0d got %b required %b", k, {state, instret}, {3'd0, expInstret});
            end
`else
            checks++;
            if ({trap, trap_cause, state, ctrlVec} !== {1'b1, 2'b01, 3'd5, C_ZERO}) begin
                errors++;
                $display("[TB] FAIL jump_trap%0d got %b required %b", k, {trap, trap_cause, state, ctrlVec}, {1'b1, 2'b01, 3'd5, C_ZERO});
            end
            rst = 1'b1;
            @(negedge clk); rst = 1'b0; #1;
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_ops();
        test_load_wait();
        test_store();
        test_branch();
        test_fetch_late();
        test_async_reset();
        test_wrap();
        test_illegal();
        test_timeout();
        test_jump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL global_timeout got running required finished");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle opcode decoder for the RV32I-subset core. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, driving datapath enables and a req/ready memory handshake. Adds a memory-timeout watchdog, illegal-opcode trapping and a retired-instruction counter. Sits between the instruction register and the shared datapath/memory port.

Parameters:
CNT_W, 32, width of retired-instruction counter instret
TIMEOUT, 16, max cycles waiting on mem_ready before bus-error trap; 0 disables watchdog
TO_W, 8, width of watchdog counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  7  instr[6:0] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory accepted/completed request this cycle
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  1=write (store), valid with mem_req
iord  out  1  memory address select: 0=PC, 1=ALU result
ir_write  out  1  load instruction register
mdr_write  out  1  load memory data register
pc_write  out  1  update PC
pc_src  out  1  0=ALU result (PC+4), 1=target register
target_write  out  1  latch branch target (PC+imm)
alu_src_a  out  1  0=PC, 1=rs1
alu_src_b  out  2  00=rs2, 01=const 4, 10=imm, 11=branch imm
alu_op_main  out  2  00=add, 01=sub/compare, 10=funct decode
reg_write_enable  out  1  register file write
mem_to_reg  out  1  writeback select: 1=MDR
trap  out  1  sticky trap flag
trap_cause  out  2  00 none, 01 illegal opcode, 10 bus timeout
instret  out  CNT_W  retired-instruction count
state  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, JUMP=6 (JUMP only with the optional feature). Registered state. All outputs are combinational from state, opcode and mem_ready. Unlisted outputs are 0.
- Reset (asynchronous): state=FETCH, instret=0, trap=0, trap_cause=00, watchdog=0. mem_req goes to 1 (FETCH) only after rst deasserts. Any in-flight request is abandoned.
- FETCH:
  - mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op_main=00.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op_main=00, target_write=1.
  - Next state: 0110011, 0010011, 0000011, 0100011 and 1100011 go to EXEC. All other opcodes go to TRAP with cause 01.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, alu_op_main=10, then WB.
  - I-type: alu_src_a=1, alu_src_b=10, alu_op_main=10, then WB.
  - Load/store: alu_src_a=1, alu_src_b=10, alu_op_main=00, then MEM.
  - Branch: alu_src_a=1, alu_src_b=00, alu_op_main=01, pc_src=1, pc_write=zero, then FETCH and retire.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for store.
  - On mem_ready: load asserts mdr_write=1 and goes to WB. Store goes to FETCH and retires.
- WB: reg_write_enable=1, mem_to_reg=1 for load, then FETCH and retire.
- Retire: instret increments by 1 on the transition edge. It wraps modulo 2^CNT_W.
- Handshake:
  - mem_req is held continuously in FETCH/MEM until mem_ready.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready in the same cycle the request is raised completes in that cycle, giving 1-cycle latency.
- Watchdog:
  - Counts cycles in FETCH/MEM with mem_ready=0. Clears on mem_ready or on state exit.
  - When count reaches TIMEOUT with mem_ready still 0, go to TRAP with cause 10. A mem_ready in that same cycle takes priority and completes normally.
- TRAP:
  - trap=1. All control outputs are 0, mem_req=0. instret is frozen.
  - Only rst exits TRAP. trap_cause is held.
- Cycle counts: R/I-type = 4 cycles, load = 5, store = 4, branch = 3, assuming 0-wait memory.

Optional Feature:
- Macro: JAL_JALR_EN.
- Defined:
  - DECODE sends opcode 1101111 (JAL) and 1100111 (JALR) to JUMP.
  - JAL in JUMP: reg_write_enable=1, mem_to_reg=0, writes PC (already PC+4) to rd; pc_write=1, pc_src=1.
  - JALR in JUMP: same writeback, but pc_src=0 with alu_src_a=1, alu_src_b=10, alu_op_main=00 (rs1+imm).
  - Both take 3 cycles, then FETCH and retire.
- Undefined: both opcodes go to TRAP with cause 01. State encoding 6 is unreachable.

Test Plan:
- 0-wait memory, R-type add: FETCH→DECODE→EXEC→WB in 4 cycles; reg_write_enable=1 in WB only; instret 0→1.
- lw with mem_ready delayed 3 cycles in MEM: mem_req held 4 cycles, mdr_write pulses once, WB has mem_to_reg=1; total 8 cycles.
- beq with zero=1 then zero=0: pc_write=1 and pc_src=1 only in the taken EXEC cycle; each branch 3 cycles.
- opcode 7'b1111111: DECODE→TRAP, trap=1, trap_cause=01, mem_req stays 0 for 20 cycles; rst pulse returns to FETCH with instret=0.
- TIMEOUT=16, mem_ready never asserted in FETCH: TRAP entered after 16 waiting cycles, trap_cause=10. mem_ready raised on cycle 16: normal completion instead.
- rst asserted asynchronously mid-MEM store: outputs clear without a clock edge, mem_we=0. CNT_W=4 running 17 retirements gives instret=1 (wrap).
